// File: rtl/swap_range_reverser.sv
// Reverses an inclusive register-file address range in place by issuing
// swap requests (lo,hi), (lo+1,hi-1), ... inward on the file's swap port.
module swap_range_reverser #(
    parameter int ADDR_WIDTH  = 7,
    parameter int SWAP_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] lo_addr,
    input  logic [ADDR_WIDTH-1:0] hi_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  swap,
    output logic [ADDR_WIDTH-1:0] address_a,
    output logic [ADDR_WIDTH-1:0] address_b,
    output logic [ADDR_WIDTH-1:0] swap_count
);

    localparam int CW = $clog2(SWAP_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(SWAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP, DONE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         hold_q, hold_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  swap_q, swap_d;
    logic [ADDR_WIDTH-1:0] address_a_q, address_a_d;
    logic [ADDR_WIDTH-1:0] address_b_q, address_b_d;
    logic [ADDR_WIDTH-1:0] swap_count_q, swap_count_d;
    logic [ADDR_WIDTH-1:0] lo_q, lo_d;
    logic [ADDR_WIDTH-1:0] hi_q, hi_d;
    logic [ADDR_WIDTH-1:0] lo_inc, hi_dec;

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        swap_d       = swap_q;
        address_a_d  = address_a_q;
        address_b_d  = address_b_q;
        swap_count_d = swap_count_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        lo_inc       = lo_q + 1'b1;
        hi_dec       = hi_q - 1'b1;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                swap_d = 1'b0;
                if (start) begin
                    lo_d         = lo_addr;
                    hi_d         = hi_addr;
                    swap_count_d = '0;
                    busy_d       = 1'b1;
                    hold_d       = '0;
                    if (lo_addr < hi_addr) begin
                        state_d     = ISSUE;
                        swap_d      = 1'b1;
                        address_a_d = lo_addr;
                        address_b_d = hi_addr;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (hold_q == HOLD_LAST) begin
                    state_d      = GAP;
                    swap_d       = 1'b0;
                    swap_count_d = swap_count_q + 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            GAP: begin
                // GAP is only entered with lo < hi, so neither step can wrap.
                lo_d   = lo_inc;
                hi_d   = hi_dec;
                hold_d = '0;
                if (lo_inc < hi_dec) begin
                    state_d     = ISSUE;
                    swap_d      = 1'b1;
                    address_a_d = lo_inc;
                    address_b_d = hi_dec;
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            swap_q       <= 1'b0;
            address_a_q  <= '0;
            address_b_q  <= '0;
            swap_count_q <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            swap_q       <= swap_d;
            address_a_q  <= address_a_d;
            address_b_q  <= address_b_d;
            swap_count_q <= swap_count_d;
        end
    end

    // Range pointers are pure data, always rewritten on an accepted start.
    always_ff @(posedge clk) begin
        lo_q <= lo_d;
        hi_q <= hi_d;
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign swap       = swap_q;
    assign address_a  = address_a_q;
    assign address_b  = address_b_q;
    assign swap_count = swap_count_q;

endmodule

// File: tb/tb_swap_range_reverser.sv
// Scoreboard bench: stimulus queues expected pairs/completions from a range
// model; a monitor checks swap pulses, done timing and a modelled register file.
module tb_swap_range_reverser;

    localparam int AW = 7;
    localparam int SC = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] lo_addr, hi_addr;
    logic          busy, done, swap;
    logic [AW-1:0] address_a, address_b, swap_count;

    swap_range_reverser #(.ADDR_WIDTH(AW), .SWAP_CYCLES(SC)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .lo_addr    (lo_addr),
        .hi_addr    (hi_addr),
        .busy       (busy),
        .done       (done),
        .swap       (swap),
        .address_a  (address_a),
        .address_b  (address_b),
        .swap_count (swap_count)
    );

    always #5 clk = ~clk;

    typedef struct { int a; int b; int stamp; } pair_t;
    typedef struct { int stamp; int count; } done_t;

    pair_t pair_q[$];
    done_t done_q[$];
    int    mem[128];
    int    edge_n = 0;
    int    n_checks = 0;
    int    n_pass = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic init_mem();
        for (int i = 0; i < 128; i++) mem[i] = i;
    endtask

    // Called at a negedge in an IDLE cycle; start is sampled at the next edge.
    task automatic launch(input int lo, input int hi, output int n);
        int e0, a, b;
        e0 = edge_n + 1;
        n  = 0;
        a  = lo;
        b  = hi;
        while (a < b) begin
            pair_q.push_back('{a, b, e0 + n * (SC + 1)});
            n++;
            a++;
            b--;
        end
        done_q.push_back('{e0 + n * (SC + 1), n});
        lo_addr = AW'(lo);
        hi_addr = AW'(hi);
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        lo_addr = AW'($urandom);
        hi_addr = AW'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 1000; i++) begin
            if (pair_q.size() == 0 && done_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain_timeout", pair_q.size() + done_q.size(), 0);
        pair_q.delete();
        done_q.delete();
        @(negedge clk);
    endtask

    initial begin : monitor
        bit    in_run, after_done;
        int    run_len, cur_a, cur_b, tmp;
        pair_t p;
        done_t d;
        in_run = 0;
        after_done = 0;
        run_len = 0;
        cur_a = 0;
        cur_b = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                in_run = 0;
                after_done = 0;
            end else begin
                if (after_done) begin
                    check("done_one_cycle", done, 0);
                    check("busy_after_done", busy, 0);
                    after_done = 0;
                end
                if (done) begin
                    if (done_q.size() == 0) check("done_unexpected", 1, 0);
                    else begin
                        d = done_q.pop_front();
                        check("done_cycle", edge_n, d.stamp);
                        check("done_count", swap_count, d.count);
                        check("done_busy", busy, 1);
                        check("done_swap", swap, 0);
                        after_done = 1;
                    end
                end
                if (swap && !in_run) begin
                    if (pair_q.size() == 0) check("swap_unexpected", 1, 0);
                    else begin
                        p = pair_q.pop_front();
                        check("pair_a", address_a, p.a);
                        check("pair_b", address_b, p.b);
                        check("pair_cycle", edge_n, p.stamp);
                        check("pair_busy", busy, 1);
                    end
                    in_run = 1;
                    run_len = 1;
                    cur_a = int'(address_a);
                    cur_b = int'(address_b);
                end else if (swap && in_run) begin
                    run_len++;
                    check("addr_stable", int'(address_a) * 256 + int'(address_b), cur_a * 256 + cur_b);
                end else if (!swap && in_run) begin
                    check("swap_len", run_len, SC);
                    check("gap_addr_hold", int'(address_a) * 256 + int'(address_b), cur_a * 256 + cur_b);
                    tmp = mem[cur_a];
                    mem[cur_a] = mem[cur_b];
                    mem[cur_b] = tmp;
                    in_run = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int n, lo, hi;
        reset   = 1'b1;
        start   = 1'b0;
        lo_addr = '0;
        hi_addr = '0;
        init_mem();
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_swap", swap, 0);
        check("rst_addr_a", address_a, 0);
        check("rst_addr_b", address_b, 0);
        check("rst_count", swap_count, 0);
        reset = 1'b0;
        @(negedge clk);

        launch(20, 29, n);
        drain();
        check("count_hold_20_29", swap_count, 5);
        check("mem20", mem[20], 29);
        check("mem24", mem[24], 25);
        check("mem25", mem[25], 24);
        check("mem29", mem[29], 20);

        init_mem();
        launch(22, 23, n);
        drain();
        check("count_hold_22_23", swap_count, 1);
        check("mem22", mem[22], 23);
        check("mem23", mem[23], 22);

        launch(30, 30, n);
        drain();
        check("count_hold_30_30", swap_count, 0);
        launch(40, 35, n);
        drain();
        check("count_hold_40_35", swap_count, 0);

        launch(0, 127, n);
        drain();
        check("count_hold_0_127", swap_count, 64);

        init_mem();
        launch(20, 29, n);
        repeat (5) @(negedge clk);
        lo_addr = 7'd1;
        hi_addr = 7'd2;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        drain();
        check("count_ignored_start", swap_count, 5);
        check("mem20_ignored", mem[20], 29);
        check("mem29_ignored", mem[29], 20);

        launch(20, 29, n);
        repeat (9) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrst_swap", swap, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_count", swap_count, 0);
        pair_q.delete();
        done_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        launch(5, 8, n);
        drain();
        check("count_after_reset", swap_count, 2);

        for (int t = 0; t < 10; t++) begin
            lo = $urandom_range(0, 127);
            hi = lo + $urandom_range(0, 40) - 8;
            if (hi < 0) hi = 0;
            if (hi > 127) hi = 127;
            launch(lo, hi, n);
            drain();
            check("count_random", swap_count, n);
            check("busy_idle_random", busy, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/swap_range_reverser.md
# swap_range_reverser

Sequencing master for the swap port of the register file. Given an inclusive address range [lo, hi], it reverses the range in place by issuing a series of swap requests on the file's swap port: (lo, hi), (lo+1, hi-1), and so on inward. It sits beside the register file and drives its `swap`, `address_a` and `address_b` inputs. The write and read ports stay with other masters.

## Interface
- ADDR_WIDTH, 7, width of register-file addresses.
- SWAP_CYCLES, 3, number of cycles `swap` is held high per pair, matching the register file's swap sequence length; must be ≥ 1.

- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- lo_addr  in  ADDR_WIDTH  first address of the range; captured on start.
- hi_addr  in  ADDR_WIDTH  last address of the range; captured on start.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- done  out  1  one-cycle completion pulse.
- swap  out  1  swap request to the register file.
- address_a  out  ADDR_WIDTH  lower address of the current pair.
- address_b  out  ADDR_WIDTH  upper address of the current pair.
- swap_count  out  ADDR_WIDTH  number of pairs issued since the last accepted start.

## Operation
- Every output is registered (Moore style); no combinational path from inputs to outputs.
- Reset values: busy=0, done=0, swap=0, address_a=0, address_b=0, swap_count=0; state=IDLE.
- Internal registers:
  - lo_r and hi_r, each ADDR_WIDTH wide, holding the current pair.
  - a hold counter, ⌈log2(SWAP_CYCLES+1)⌉ bits wide.
- States:
  - IDLE: outputs quiescent. If start=1, capture lo_r=lo_addr, hi_r=hi_addr and clear swap_count. Go to ISSUE if lo_addr < hi_addr (unsigned); otherwise go to DONE.
  - ISSUE:
    - swap=1, address_a=lo_r, address_b=hi_r, all held stable.
    - After SWAP_CYCLES cycles, increment swap_count and go to GAP.
  - GAP:
    - swap=0; addresses hold their last value.
    - Update lo_r+1 and hi_r-1.
    - If the updated lo_r < hi_r, go to ISSUE; otherwise go to DONE.
  - DONE: done=1 for exactly one cycle, swap=0, then go to IDLE.
- Pair count N = ⌊(hi−lo+1)/2⌋ when lo < hi, else 0. For an odd-length range the middle element is never touched.
- No wrap-around is possible:
  - lo_r is only incremented while lo_r < hi_r, so it never exceeds the maximum address.
  - hi_r ≥ 1 whenever it is decremented.
- swap_count holds its final value after DONE until the next accepted start. Maximum value 2^(ADDR_WIDTH−1) fits in ADDR_WIDTH bits.
- start is ignored in every state other than IDLE, including DONE. lo_addr and hi_addr may change freely once captured.
- Reset asserted mid-operation: all outputs go to their reset values immediately (asynchronously) and the state goes to IDLE. A swap sequence already begun inside the register file is not this block's concern.

## Timing
- Edge E0 samples start=1 in IDLE. Following ISSUE→GAP sequencing, the first ISSUE cycle is E0→E1.
- Each pair occupies SWAP_CYCLES + 1 cycles (ISSUE plus GAP). A one-cycle `swap` low gap always separates pairs.
- done is high in cycle N·(SWAP_CYCLES+1) after E0; busy falls with it.
  - With defaults: N=5 gives done at cycle 20 after E0.
  - With N=0 (lo ≥ hi): done and busy are high only in cycle E0→E1, and swap never asserts.
- A new start can be accepted on the first cycle after DONE (back-to-back ranges are allowed).

## Test plan
- Register file with locations 20..29 filled with value=i; start with lo=20, hi=29.
  - Required: 5 pairs issued, (20,29), (21,28), (22,27), (23,26), (24,25), each with swap high for 3 cycles then low for 1.
  - done at cycle 20 after the start edge; swap_count=5.
  - Readback: loc 20=29, 24=25, 25=24, 29=20.
- lo=22, hi=23: one swap (22,23), done at cycle 4, swap_count=1; readback 22=23, 23=22.
- lo=30, hi=30, and separately lo=40, hi=35: no swap pulse, done one cycle after start, swap_count=0.
- lo=0, hi=127: 64 pairs; the last pair is (63,64); swap_count=64; done at cycle 256. No address wraps.
- start re-pulsed with lo=1, hi=2 in the middle of the 20..29 run: ignored, and the original sequence completes unchanged.
- reset asserted during the third pair: swap, busy and done drop to 0 asynchronously. The next start with lo=5, hi=8 runs cleanly: 2 pairs, swap_count=2.
